// File: rtl/avalon_arb_pkg.sv
// Shared definitions for the dual-master Avalon-MM arbiter: FSM encoding,
// master identifiers and default bus widths.
package avalon_arb_pkg;

    localparam int ADDR_W_DEF    = 26;
    localparam int DATA_W_DEF    = 128;
    localparam int PEND_LOG2_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    typedef logic master_id_t;

    localparam master_id_t M0 = 1'b0;
    localparam master_id_t M1 = 1'b1;

endpackage

// File: rtl/avalon_dual_master_arbiter_if.sv
// One Avalon-MM command/response link. The master modport issues commands,
// the slave modport answers them; the arbiter is a slave towards each local
// master and a master towards the DDR3 controller.
interface avalon_dual_master_arbiter_if #(
    parameter int ADDR_W = avalon_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = avalon_arb_pkg::DATA_W_DEF
);

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              read;
    logic              write;
    logic              waitrequest_n;
    logic              readdatavalid;
    logic [DATA_W-1:0] readdata;

    modport master (
        output addr, wdata, read, write,
        input  waitrequest_n, readdatavalid, readdata
    );

    modport slave (
        input  addr, wdata, read, write,
        output waitrequest_n, readdatavalid, readdata
    );

endinterface

// File: rtl/avalon_tag_fifo.sv
// In-order FIFO of 1-bit master tags, one entry per outstanding read.
// Push/pop are expected to be pre-qualified by the caller but are guarded
// against overflow/underflow here as well.
module avalon_tag_fifo #(
    parameter int PEND_LOG2 = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               push_id,
    input  logic               pop,
    output logic               head_id,
    output logic               full,
    output logic               empty,
    output logic [PEND_LOG2:0] count
);

    localparam int DEPTH = 2 ** PEND_LOG2;
    localparam logic [PEND_LOG2-1:0] PTR_ONE   = PEND_LOG2'(1);
    localparam logic [PEND_LOG2:0]   CNT_ONE   = (PEND_LOG2 + 1)'(1);
    localparam logic [PEND_LOG2:0]   CNT_DEPTH = (PEND_LOG2 + 1)'(DEPTH);

    logic [DEPTH-1:0]     mem_q, mem_d;
    logic [PEND_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [PEND_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [PEND_LOG2:0]   count_q, count_d;
    logic                 do_push, do_pop;

    // Pointer/count update; pointers wrap naturally at the power-of-two depth
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Status and head-of-queue view
    always_comb begin
        full    = (count_q == CNT_DEPTH);
        empty   = (count_q == '0);
        count   = count_q;
        head_id = mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/avalon_dual_master_arbiter.sv
// Round-robin arbiter sharing the DDR3 controller's Avalon-MM port between
// two local masters, one command per grant, with read data routed back
// through an in-order tag FIFO.
module avalon_dual_master_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PEND_LOG2 = PEND_LOG2_DEF
) (
    input  logic                          iCLK,
    input  logic                          iRST_n,
    input  logic                          local_init_done,
    avalon_dual_master_arbiter_if.slave   m0,
    avalon_dual_master_arbiter_if.slave   m1,
    avalon_dual_master_arbiter_if.master  avl,
    output logic                          avl_burstbegin,
    output logic [PEND_LOG2:0]            pend_cnt,
    output logic                          arb_err
);

    arb_state_e state_q, state_d;
    master_id_t last_grant_q, last_grant_d;
    logic       arb_err_q, arb_err_d;

    logic fifo_full, fifo_empty, fifo_head, fifo_push, fifo_pop;

    logic m0_wr, m0_rd, m1_wr, m1_rd, req0, req1;

    logic              sel_valid, sel_wr, sel_rd, sel_both, cmd_accept;
    master_id_t        granted_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Qualify requests: write beats read, reads held off while the tag FIFO is full
    always_comb begin
        m0_wr = m0.write;
        m0_rd = m0.read & ~m0.write & ~fifo_full;
        m1_wr = m1.write;
        m1_rd = m1.read & ~m1.write & ~fifo_full;
        req0  = m0_wr | m0_rd;
        req1  = m1_wr | m1_rd;
    end

    // Select the granted master's command and detect acceptance by the controller
    always_comb begin
        sel_valid  = 1'b0;
        granted_id = M0;
        sel_wr     = 1'b0;
        sel_rd     = 1'b0;
        sel_both   = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        unique case (state_q)
            GRANT0: begin
                sel_valid  = 1'b1;
                granted_id = M0;
                sel_wr     = m0_wr;
                sel_rd     = m0_rd;
                sel_both   = m0.read & m0.write;
                sel_addr   = m0.addr;
                sel_wdata  = m0.wdata;
            end
            GRANT1: begin
                sel_valid  = 1'b1;
                granted_id = M1;
                sel_wr     = m1_wr;
                sel_rd     = m1_rd;
                sel_both   = m1.read & m1.write;
                sel_addr   = m1.addr;
                sel_wdata  = m1.wdata;
            end
            default: ;
        endcase
        cmd_accept = sel_valid & avl.waitrequest_n & (sel_wr | sel_rd);
    end

    // State, round-robin pointer and sticky error flag
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_q      <= IDLE;
            last_grant_q <= M1;
            arb_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            arb_err_q    <= arb_err_d;
        end
    end

    // Next-state: grant from IDLE, return to IDLE after acceptance or a withdrawn request
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        arb_err_d    = arb_err_q;
        case (state_q)
            IDLE: begin
                if (local_init_done) begin
                    if (req0 && req1) begin
                        state_d = (last_grant_q == M0) ? GRANT1 : GRANT0;
                    end else if (req0) begin
                        state_d = GRANT0;
                    end else if (req1) begin
                        state_d = GRANT1;
                    end
                end
            end
            GRANT0, GRANT1: begin
                if (sel_both) begin
                    arb_err_d = 1'b1;
                end
                if (!(sel_wr || sel_rd)) begin
                    state_d   = IDLE;
                    arb_err_d = 1'b1;
                end else if (cmd_accept) begin
                    state_d      = IDLE;
                    last_grant_d = granted_id;
                end
            end
            default: state_d = IDLE;
        endcase
        if (avl.readdatavalid && fifo_empty) begin
            arb_err_d = 1'b1;
        end
    end

    // Outputs: controller command mux, per-master handshakes and read-data routing
    always_comb begin
        avl.addr         = sel_addr;
        avl.wdata        = sel_wdata;
        avl.write        = sel_wr;
        avl.read         = sel_rd;
        avl_burstbegin   = sel_wr | sel_rd;
        m0.waitrequest_n = (state_q == GRANT0) & avl.waitrequest_n;
        m1.waitrequest_n = (state_q == GRANT1) & avl.waitrequest_n;
        fifo_push        = cmd_accept & sel_rd;
        fifo_pop         = avl.readdatavalid & ~fifo_empty;
        m0.readdatavalid = fifo_pop & (fifo_head == M0);
        m1.readdatavalid = fifo_pop & (fifo_head == M1);
        m0.readdata      = avl.readdata;
        m1.readdata      = avl.readdata;
        arb_err          = arb_err_q;
    end

    avalon_tag_fifo #(
        .PEND_LOG2 (PEND_LOG2)
    ) u_tag_fifo (
        .clk     (iCLK),
        .rst_n   (iRST_n),
        .push    (fifo_push),
        .push_id (granted_id),
        .pop     (fifo_pop),
        .head_id (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (pend_cnt)
    );

endmodule

// File: tb/tb_avalon_dual_master_arbiter.sv
// Self-checking bench for avalon_dual_master_arbiter: directed scenarios
// followed by randomized traffic, all compared against a transaction-level
// reference model (owner id, round-robin turn, queue of read tags).
module tb_avalon_dual_master_arbiter;
    import avalon_arb_pkg::*;

    localparam int ADDR_W    = 26;
    localparam int DATA_W    = 128;
    localparam int PEND_LOG2 = 3;
    localparam int DEPTH     = 8;

    logic               iCLK = 1'b0;
    logic               iRST_n;
    logic               local_init_done;
    logic               avl_burstbegin;
    logic               arb_err;
    logic [PEND_LOG2:0] pend_cnt;

    avalon_dual_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    avalon_dual_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
    avalon_dual_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avl_if ();

    avalon_dual_master_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .PEND_LOG2 (PEND_LOG2)
    ) dut (
        .iCLK            (iCLK),
        .iRST_n          (iRST_n),
        .local_init_done (local_init_done),
        .m0              (m0_if),
        .m1              (m1_if),
        .avl             (avl_if),
        .avl_burstbegin  (avl_burstbegin),
        .pend_cnt        (pend_cnt),
        .arb_err         (arb_err)
    );

    always #5 iCLK = ~iCLK;

    // Reference model state
    int owner       = -1;
    int last_id     = 1;
    int tag_q[$];
    bit err_m       = 1'b0;
    bit model_valid = 1'b0;

    int cycle      = 0;
    int compared   = 0;
    int mismatched = 0;
    int ops_left[2];
    bit acc_m[2];

    int accept_log[$];
    int accept_cyc[$];
    int route_log[$];

    logic              obs_write, obs_read, obs_err;
    logic [ADDR_W-1:0] obs_addr;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic bit in_read(input int n);
        return (n == 0) ? m0_if.read : m1_if.read;
    endfunction

    function automatic bit in_write(input int n);
        return (n == 0) ? m0_if.write : m1_if.write;
    endfunction

    function automatic logic [ADDR_W-1:0] in_addr(input int n);
        return (n == 0) ? m0_if.addr : m1_if.addr;
    endfunction

    function automatic logic [DATA_W-1:0] in_wdata(input int n);
        return (n == 0) ? m0_if.wdata : m1_if.wdata;
    endfunction

    task automatic setMaster(input int n, input bit rd, input bit wr, input int ops);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        a = ADDR_W'($urandom);
        d = {$urandom, $urandom, $urandom, $urandom};
        if (n == 0) begin
            m0_if.read = rd; m0_if.write = wr; m0_if.addr = a; m0_if.wdata = d;
        end else begin
            m1_if.read = rd; m1_if.write = wr; m1_if.addr = a; m1_if.wdata = d;
        end
        ops_left[n] = ops;
    endtask

    // One clock: check outputs against the model at negedge, advance the model, let masters react
    task automatic runCycle();
        bit full, exp_rd, exp_wr, exp_pop, acc, rw_both, req0, req1;
        logic [7:0] exp_ctrl, got_ctrl;
        @(negedge iCLK);
        cycle++;
        full    = (tag_q.size() == DEPTH);
        exp_rd  = 1'b0;
        exp_wr  = 1'b0;
        rw_both = 1'b0;
        if (owner >= 0) begin
            exp_wr  = in_write(owner);
            exp_rd  = in_read(owner) && !in_write(owner) && !full;
            rw_both = in_read(owner) && in_write(owner);
        end
        exp_pop  = avl_if.readdatavalid && (tag_q.size() > 0);
        acc      = (owner >= 0) && avl_if.waitrequest_n && (exp_rd || exp_wr);
        acc_m[0] = acc && (owner == 0);
        acc_m[1] = acc && (owner == 1);

        obs_write = avl_if.write;
        obs_read  = avl_if.read;
        obs_err   = arb_err;
        obs_addr  = avl_if.addr;

        if (model_valid) begin
            exp_ctrl = {exp_rd, exp_wr, exp_rd | exp_wr,
                        (owner == 0) && avl_if.waitrequest_n,
                        (owner == 1) && avl_if.waitrequest_n,
                        exp_pop && (tag_q[0] == 0),
                        exp_pop && (tag_q[0] == 1),
                        err_m};
            got_ctrl = {avl_if.read, avl_if.write, avl_burstbegin,
                        m0_if.waitrequest_n, m1_if.waitrequest_n,
                        m0_if.readdatavalid, m1_if.readdatavalid, arb_err};
            checkOutput("ctrl{rd,wr,bb,wrn0,wrn1,rdv0,rdv1,err}", got_ctrl, exp_ctrl);
            checkOutput("pend_cnt", pend_cnt, tag_q.size());
            if (exp_rd || exp_wr) begin
                checkOutput("avl_addr", avl_if.addr, in_addr(owner));
                if (exp_wr) checkOutput("avl_wdata", avl_if.wdata, in_wdata(owner));
            end
            if (exp_pop) begin
                checkOutput("m0_readdata", m0_if.readdata, avl_if.readdata);
                checkOutput("m1_readdata", m1_if.readdata, avl_if.readdata);
            end
        end

        if ((avl_if.read || avl_if.write) && avl_if.waitrequest_n) begin
            if (m0_if.waitrequest_n) begin
                accept_log.push_back(0); accept_cyc.push_back(cycle);
            end else if (m1_if.waitrequest_n) begin
                accept_log.push_back(1); accept_cyc.push_back(cycle);
            end
        end
        if (m0_if.readdatavalid) route_log.push_back(0);
        if (m1_if.readdatavalid) route_log.push_back(1);

        if (!iRST_n) begin
            owner = -1; last_id = 1; tag_q.delete(); err_m = 1'b0; model_valid = 1'b1;
        end else if (model_valid) begin
            if (avl_if.readdatavalid && tag_q.size() == 0) err_m = 1'b1;
            if (exp_pop) void'(tag_q.pop_front());
            if (acc && exp_rd) tag_q.push_back(owner);
            if (owner >= 0) begin
                if (rw_both) err_m = 1'b1;
                if (!(exp_rd || exp_wr)) begin
                    err_m = 1'b1; owner = -1;
                end else if (acc) begin
                    last_id = owner; owner = -1;
                end
            end else if (local_init_done) begin
                req0 = m0_if.write || (m0_if.read && !full);
                req1 = m1_if.write || (m1_if.read && !full);
                if (req0 && req1) owner = (last_id == 0) ? 1 : 0;
                else if (req0)    owner = 0;
                else if (req1)    owner = 1;
            end
        end

        @(posedge iCLK);
        #1;
        for (int n = 0; n < 2; n++) begin
            if (acc_m[n] && ops_left[n] > 0) begin
                ops_left[n]--;
                if (ops_left[n] == 0) setMaster(n, 1'b0, 1'b0, 0);
                else setMaster(n, in_read(n), in_write(n), ops_left[n]);
            end
        end
    endtask

    task automatic resetDut();
        iRST_n = 1'b0;
        setMaster(0, 1'b0, 1'b0, 0);
        setMaster(1, 1'b0, 1'b0, 0);
        avl_if.readdatavalid = 1'b0;
        avl_if.waitrequest_n = 1'b1;
        avl_if.readdata      = '0;
        repeat (2) runCycle();
        iRST_n = 1'b1;
    endtask

    // Random traffic: masters issue single commands, controller stalls and returns data
    task automatic applyStimulus();
        local_init_done      = ($urandom_range(0, 19) != 0);
        avl_if.waitrequest_n = ($urandom_range(0, 9) < 7);
        avl_if.readdatavalid = (tag_q.size() > 0) && ($urandom_range(0, 9) < 4);
        avl_if.readdata      = {$urandom, $urandom, $urandom, $urandom};
        for (int n = 0; n < 2; n++) begin
            if (ops_left[n] == 0 && $urandom_range(0, 9) < 3) begin
                if ($urandom_range(0, 1) == 1) setMaster(n, 1'b1, 1'b0, 1);
                else                           setMaster(n, 1'b0, 1'b1, 1);
            end
        end
        iRST_n = ($urandom_range(0, 299) != 0);
    endtask

    initial begin
        logic [ADDR_W-1:0] t1_addr;
        int t3_exp[5];
        int ones;
        t3_exp = '{0, 1, 0, 1, 0};
        local_init_done = 1'b0;

        // 1: no grant before calibration, write one cycle after init_done rises
        resetDut();
        local_init_done = 1'b0;
        setMaster(0, 1'b0, 1'b1, 1);
        t1_addr = m0_if.addr;
        for (int i = 0; i < 20; i++) begin
            runCycle();
            checkOutput("t1_no_write_before_init", obs_write, 1'b0);
        end
        local_init_done = 1'b1;
        runCycle();
        checkOutput("t1_idle_cycle", obs_write, 1'b0);
        runCycle();
        checkOutput("t1_write_after_init", obs_write, 1'b1);
        checkOutput("t1_addr", obs_addr, t1_addr);

        // 2: continuous writes from both masters alternate with one bubble each
        resetDut();
        local_init_done = 1'b1;
        setMaster(0, 1'b0, 1'b1, 1000);
        setMaster(1, 1'b0, 1'b1, 1000);
        accept_log.delete(); accept_cyc.delete();
        repeat (12) runCycle();
        checkOutput("t2_accept_count", accept_log.size() >= 4, 1'b1);
        if (accept_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) checkOutput("t2_order", accept_log[i], i % 2);
            for (int i = 1; i < 4; i++) checkOutput("t2_gap", accept_cyc[i] - accept_cyc[i-1], 2);
        end

        // 3: interleaved reads, in-order returns routed to the issuing master
        resetDut();
        local_init_done = 1'b1;
        setMaster(0, 1'b1, 1'b0, 3);
        setMaster(1, 1'b1, 1'b0, 2);
        accept_log.delete(); route_log.delete();
        repeat (14) runCycle();
        checkOutput("t3_accepts", accept_log.size(), 5);
        checkOutput("t3_pend", pend_cnt, 5);
        for (int i = 0; i < 5; i++) begin
            avl_if.readdatavalid = 1'b1;
            avl_if.readdata      = {$urandom, $urandom, $urandom, $urandom};
            runCycle();
        end
        avl_if.readdatavalid = 1'b0;
        checkOutput("t3_routes", route_log.size(), 5);
        if (route_log.size() == 5) begin
            for (int i = 0; i < 5; i++) checkOutput("t3_route", route_log[i], t3_exp[i]);
        end

        // 4: full tag FIFO stalls reads but not writes; one return frees a slot
        resetDut();
        local_init_done = 1'b1;
        setMaster(0, 1'b1, 1'b0, 9);
        repeat (24) runCycle();
        checkOutput("t4_pend_full", pend_cnt, 8);
        accept_log.delete();
        repeat (6) runCycle();
        checkOutput("t4_ninth_stalled", accept_log.size(), 0);
        setMaster(1, 1'b0, 1'b1, 1);
        repeat (4) runCycle();
        ones = 0;
        foreach (accept_log[i]) if (accept_log[i] == 1) ones++;
        checkOutput("t4_m1_write_accepted", ones, 1);
        checkOutput("t4_only_m1", accept_log.size(), 1);
        accept_log.delete();
        avl_if.readdatavalid = 1'b1;
        avl_if.readdata      = {$urandom, $urandom, $urandom, $urandom};
        runCycle();
        avl_if.readdatavalid = 1'b0;
        repeat (4) runCycle();
        checkOutput("t4_ninth_granted", accept_log.size(), 1);
        checkOutput("t4_pend_after", pend_cnt, 8);

        // 5: read accepted in the same cycle as a return
        resetDut();
        local_init_done = 1'b1;
        setMaster(0, 1'b1, 1'b0, 1);
        runCycle(); runCycle();
        setMaster(1, 1'b1, 1'b0, 1);
        runCycle();
        route_log.delete(); accept_log.delete();
        avl_if.readdatavalid = 1'b1;
        avl_if.readdata      = {$urandom, $urandom, $urandom, $urandom};
        runCycle();
        avl_if.readdatavalid = 1'b0;
        checkOutput("t5_accept", accept_log.size(), 1);
        checkOutput("t5_pend_same", pend_cnt, 1);
        checkOutput("t5_route_count", route_log.size(), 1);
        if (route_log.size() == 1) checkOutput("t5_route_m0", route_log[0], 0);
        avl_if.readdatavalid = 1'b1;
        runCycle();
        avl_if.readdatavalid = 1'b0;
        checkOutput("t5_pend_empty", pend_cnt, 0);
        checkOutput("t5_route_count2", route_log.size(), 2);
        if (route_log.size() == 2) checkOutput("t5_route_m1", route_log[1], 1);

        // 6: protocol errors are sticky until reset
        resetDut();
        local_init_done = 1'b1;
        avl_if.readdatavalid = 1'b1;
        runCycle();
        avl_if.readdatavalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            runCycle();
            checkOutput("t6_err_sticky", obs_err, 1'b1);
        end
        resetDut();
        local_init_done = 1'b1;
        runCycle();
        checkOutput("t6_err_cleared", obs_err, 1'b0);
        setMaster(1, 1'b1, 1'b1, 1);
        runCycle();
        runCycle();
        checkOutput("t6_rw_write_wins", obs_write, 1'b1);
        checkOutput("t6_rw_read_masked", obs_read, 1'b0);
        runCycle();
        checkOutput("t6_rw_err", obs_err, 1'b1);
        resetDut();
        local_init_done = 1'b1;
        avl_if.waitrequest_n = 1'b0;
        setMaster(0, 1'b0, 1'b1, 0);
        runCycle();
        setMaster(0, 1'b0, 1'b0, 0);
        runCycle();
        runCycle();
        checkOutput("t6_drop_err", obs_err, 1'b1);

        // Randomized traffic against the model
        resetDut();
        local_init_done = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            runCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
